morse_encoder: RTL and testbench
================================

// Module: morse_encoder
// PURPOSE
//  Transmit-side counterpart of the Morse letter decoder FSM. Accepts ASCII characters over a
//  valid/ready handshake and emits the matching Morse symbol stream (DIT/DAH/GAP/SPACE).
//  Symbols use the 3-bit codes the decoder consumes, so the output can drive it directly.
//  An optional keyer produces a timed on/off key line for a tone generator or LED.
// PARAMETERS
//  UNIT_CYCLES  10  clk cycles per Morse time unit (keyer only; legal range >=1)
// PORTS
//  clk        in   1  single clock, rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  char_in    in   8  ASCII character
//  char_valid in   1  char_in valid
//  char_ready out  1  encoder can accept a character
//  sym_out    out  3  symbol: WAIT=0, DIT=1, DAH=2, GAP=3, SPACE=4
//  sym_valid  out  1  sym_out holds a real symbol
//  sym_ready  in   1  downstream accepts sym_out
//  bad_char   out  1  1-cycle pulse when an unsupported character is accepted
//  key_out    out  1  [MORSE_KEY_EN only] keyed line, 1 = tone on
// BEHAVIOUR
//  - Reset (async): state=IDLE; char_ready=1, sym_valid=0, sym_out=WAIT, bad_char=0, key_out=0.
//  - Accepted character: char_valid & char_ready.
//  - Accepted symbol: sym_valid & sym_ready (& keyer idle when MORSE_KEY_EN is defined).
//  - sym_out=WAIT whenever sym_valid=0. sym_out is held stable while sym_valid & !sym_ready.
//  - FSM states IDLE, ELEM, GAPS, SPC:
//    IDLE: char_ready=1; the other states drive char_ready=0.
//      Char accepted in cycle N -> new state and registered symbol valid in cycle N+1.
//      'A'-'Z' and 'a'-'z' (folded to upper case) -> ELEM; latch 4-bit pattern (MSB first, 1=dah)
//        and length 1..4 from the table.
//      0x20 -> SPC.
//      Any other value -> stay IDLE; bad_char=1 in cycle N+1; no symbols emitted.
//    ELEM: present the element at index idx (0..len-1). On accept: idx++; after the last element -> GAPS.
//    GAPS: present GAP; on accept -> IDLE.
//    SPC:  present SPACE; on accept -> IDLE. The decoder is at start after the previous GAP.
//  - Examples: 'E' -> DIT,GAP. 'Q' -> DAH,DAH,DIT,DAH,GAP. 'X' -> DAH,DIT,DIT,DAH,GAP.
//  - Throughput with sym_ready=1 and no keyer: len+1 symbols per letter, then 1 IDLE cycle before the next accept.
//  - Reset mid-character aborts it; no trailing GAP is emitted after reset release.
// CONFIGURATION
//  MORSE_KEY_EN defined: instantiate keyer; add key_out.
//    The keyer stalls symbol acceptance while it is busy.
//    Per accepted symbol:
//      DIT: key 1 for 1 unit, then 0 for 1 unit.
//      DAH: key 1 for 3 units, then 0 for 1 unit.
//      GAP: 0 for 2 units (3 units of silence after the letter).
//      SPACE: 0 for 4 units (7 units total after a GAP).
//    1 unit = UNIT_CYCLES clk. key_out rises the cycle after the accept.
//  MORSE_KEY_EN undefined: no keyer, no key_out port; acceptance = sym_valid & sym_ready.
// STRUCTURE
//  morse_pkg (shared with decoder):
//    - symbol code constants WAIT/DIT/DAH/GAP/SPACE
//    - ASCII constants ('A', 'Z', 'a', 0x20)
//    - letter->{len[2:0], pat[3:0]} table function
//    - FSM state encoding
//  Sub-module morse_keyer (MORSE_KEY_EN only):
//    - inputs: symbol + accept strobe
//    - outputs: key_out, busy
//    - unit counter width $clog2(4*UNIT_CYCLES+1)
// TESTING
//  1 'E', sym_ready=1 -> sym_out DIT, GAP on consecutive cycles; char_ready back to 1 after.
//  2 'q' with sym_ready low for 3 cycles on the 2nd symbol -> DAH,DAH(held 4 cycles),DIT,DAH,GAP.
//  3 'H',0x20,'I' back-to-back -> DIT x4,GAP,SPACE,DIT,DIT,GAP; decoder model reads "H I".
//  4 '5' (0x35) -> bad_char pulse 1 cycle, sym_valid stays 0, char_ready stays 1.
//  5 rst_n low during 2nd element of 'B' -> outputs at reset values immediately; next 'T' -> DAH,GAP.
//  6 MORSE_KEY_EN, UNIT_CYCLES=4, 'A' -> key_out 1x4,0x4,1x12,0x4,0x8 cycles; next accept after 32 cycles.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared Morse definitions: symbol codes, ASCII bounds, letter table, FSM states.
// Used by both the encoder (and its optional MORSE_KEY_EN keyer) and the decoder.
package morse_pkg;

    localparam logic [2:0] SYM_WAIT  = 3'd0;
    localparam logic [2:0] SYM_DIT   = 3'd1;
    localparam logic [2:0] SYM_DAH   = 3'd2;
    localparam logic [2:0] SYM_GAP   = 3'd3;
    localparam logic [2:0] SYM_SPACE = 3'd4;

    localparam logic [7:0] ASC_A  = 8'h41;
    localparam logic [7:0] ASC_Z  = 8'h5A;
    localparam logic [7:0] ASC_LA = 8'h61;
    localparam logic [7:0] ASC_LZ = 8'h7A;
    localparam logic [7:0] ASC_SP = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ELEM,
        ST_GAPS,
        ST_SPC
    } state_t;

    typedef struct packed {
        logic [2:0] len;
        logic [3:0] pat;
    } code_t;

    // Pattern is left-aligned, MSB first, 1 = dah.
    function automatic code_t letter_code(input logic [7:0] c);
        logic [7:0] i;
        logic [6:0] r;
        i = c - ASC_A;
        case (i)
            8'd0:  r = {3'd2, 4'b0100};
            8'd1:  r = {3'd4, 4'b1000};
            8'd2:  r = {3'd4, 4'b1010};
            8'd3:  r = {3'd3, 4'b1000};
            8'd4:  r = {3'd1, 4'b0000};
            8'd5:  r = {3'd4, 4'b0010};
            8'd6:  r = {3'd3, 4'b1100};
            8'd7:  r = {3'd4, 4'b0000};
            8'd8:  r = {3'd2, 4'b0000};
            8'd9:  r = {3'd4, 4'b0111};
            8'd10: r = {3'd3, 4'b1010};
            8'd11: r = {3'd4, 4'b0100};
            8'd12: r = {3'd2, 4'b1100};
            8'd13: r = {3'd2, 4'b1000};
            8'd14: r = {3'd3, 4'b1110};
            8'd15: r = {3'd4, 4'b0110};
            8'd16: r = {3'd4, 4'b1101};
            8'd17: r = {3'd3, 4'b0100};
            8'd18: r = {3'd3, 4'b0000};
            8'd19: r = {3'd1, 4'b1000};
            8'd20: r = {3'd3, 4'b0010};
            8'd21: r = {3'd4, 4'b0001};
            8'd22: r = {3'd3, 4'b0110};
            8'd23: r = {3'd4, 4'b1001};
            8'd24: r = {3'd4, 4'b1011};
            8'd25: r = {3'd4, 4'b1100};
            default: r = 7'd0;
        endcase
        return code_t'(r);
    endfunction

    function automatic logic [2:0] elem_sym(
        input logic [3:0] pat,
        input logic [1:0] idx
    );
        return pat[2'd3 - idx] ? SYM_DAH : SYM_DIT;
    endfunction

endpackage

// File: rtl/morse_keyer.sv
// Timed key line for one accepted Morse symbol; busy stalls the next accept.
// Instantiated by morse_encoder only when MORSE_KEY_EN is defined.
module morse_keyer
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] sym,
    input  logic       acc,
    output logic       key_out,
    output logic       busy
);

    localparam int CW = $clog2(4 * UNIT_CYCLES + 1);
    localparam logic [CW-1:0] U1 = CW'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] U2 = CW'(2 * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] U3 = CW'(3 * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] U4 = CW'(4 * UNIT_CYCLES - 1);

    logic          active;
    logic          off_ph;
    logic [CW-1:0] cnt;
    logic [CW-1:0] off_ld;

    // Free during the final off cycle so back-to-back symbols abut.
    assign busy = active & ~(off_ph & (cnt == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active  <= 1'b0;
            off_ph  <= 1'b0;
            cnt     <= '0;
            off_ld  <= '0;
            key_out <= 1'b0;
        end else if (acc) begin
            active <= 1'b1;
            off_ld <= U1;
            unique case (sym)
                SYM_DIT: begin
                    key_out <= 1'b1;
                    off_ph  <= 1'b0;
                    cnt     <= U1;
                end
                SYM_DAH: begin
                    key_out <= 1'b1;
                    off_ph  <= 1'b0;
                    cnt     <= U3;
                end
                SYM_GAP: begin
                    key_out <= 1'b0;
                    off_ph  <= 1'b1;
                    cnt     <= U2;
                end
                default: begin
                    key_out <= 1'b0;
                    off_ph  <= 1'b1;
                    cnt     <= U4;
                end
            endcase
        end else if (active) begin
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else if (!off_ph) begin
                off_ph  <= 1'b1;
                key_out <= 1'b0;
                cnt     <= off_ld;
            end else begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/morse_encoder.sv
// ASCII to Morse symbol stream encoder with valid/ready on both sides.
// Define MORSE_KEY_EN to add the timed key_out line (keyer stalls symbol accepts).
module morse_encoder
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic [2:0] sym_out,
    output logic       sym_valid,
    input  logic       sym_ready,
    output logic       bad_char
`ifdef MORSE_KEY_EN
    ,
    output logic       key_out
`endif
);

    if (UNIT_CYCLES < 1) begin : g_unit_chk
        $error("UNIT_CYCLES must be >= 1");
    end

    state_t     state;
    logic [3:0] pat;
    logic [2:0] len;
    logic [1:0] idx;
    logic       key_busy;
    logic       sym_acc;
    logic [7:0] up;
    logic       is_letter;
    logic       is_space;
    code_t      code;

    assign up = (char_in >= ASC_LA && char_in <= ASC_LZ) ?
                char_in - 8'h20 : char_in;
    assign is_letter = (up >= ASC_A) && (up <= ASC_Z);
    assign is_space  = (char_in == ASC_SP);
    assign code      = letter_code(up);
    assign sym_acc   = sym_valid & sym_ready & ~key_busy;

`ifdef MORSE_KEY_EN
    morse_keyer #(
        .UNIT_CYCLES(UNIT_CYCLES)
    ) u_keyer (
        .clk    (clk),
        .rst_n  (rst_n),
        .sym    (sym_out),
        .acc    (sym_acc),
        .key_out(key_out),
        .busy   (key_busy)
    );
`else
    assign key_busy = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pat        <= '0;
            len        <= '0;
            idx        <= '0;
            sym_out    <= SYM_WAIT;
            sym_valid  <= 1'b0;
            char_ready <= 1'b1;
            bad_char   <= 1'b0;
        end else begin
            bad_char <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (char_valid) begin
                        if (is_letter) begin
                            state      <= ST_ELEM;
                            pat        <= code.pat;
                            len        <= code.len;
                            idx        <= 2'd0;
                            sym_out    <= elem_sym(code.pat, 2'd0);
                            sym_valid  <= 1'b1;
                            char_ready <= 1'b0;
                        end else if (is_space) begin
                            state      <= ST_SPC;
                            sym_out    <= SYM_SPACE;
                            sym_valid  <= 1'b1;
                            char_ready <= 1'b0;
                        end else begin
                            bad_char <= 1'b1;
                        end
                    end
                end
                ST_ELEM: begin
                    if (sym_acc) begin
                        if ({1'b0, idx} == len - 3'd1) begin
                            state   <= ST_GAPS;
                            sym_out <= SYM_GAP;
                        end else begin
                            idx     <= idx + 2'd1;
                            sym_out <= elem_sym(pat, idx + 2'd1);
                        end
                    end
                end
                ST_GAPS, ST_SPC: begin
                    if (sym_acc) begin
                        state      <= ST_IDLE;
                        sym_out    <= SYM_WAIT;
                        sym_valid  <= 1'b0;
                        char_ready <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_morse_encoder.sv
// Scoreboard bench for morse_encoder: directed characters, decoder model on output.
// Builds with or without MORSE_KEY_EN.
module tb_morse_encoder;
    import morse_pkg::*;

`ifdef MORSE_KEY_EN
    localparam int UC = 4;
`else
    localparam int UC = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] char_in = 8'h00;
    logic       char_valid = 1'b0;
    logic       sym_ready = 1'b1;
    logic       char_ready;
    logic [2:0] sym_out;
    logic       sym_valid;
    logic       bad_char;
`ifdef MORSE_KEY_EN
    logic       key_out;
`endif

    morse_encoder #(
        .UNIT_CYCLES(UC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .char_in   (char_in),
        .char_valid(char_valid),
        .char_ready(char_ready),
        .sym_out   (sym_out),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .bad_char  (bad_char)
`ifdef MORSE_KEY_EN
        ,
        .key_out   (key_out)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [2:0] exp_q[$];
    string pat_s = "";
    string decoded = "";
    string tbl[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.",
                       "....", "..", ".---", "-.-", ".-..", "--", "-.",
                       "---", ".--.", "--.-", ".-.", "...", "-", "..-",
                       "...-", ".--", "-..-", "-.--", "--.."};

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_str(input string name, input string act,
                             input string exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
        end
    endtask

    function automatic void push_char(input logic [7:0] c);
        logic [7:0] u;
        string p;
        u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
        if (u >= 8'h41 && u <= 8'h5A) begin
            p = tbl[u - 8'h41];
            for (int i = 0; i < p.len(); i++)
                exp_q.push_back(p[i] == "-" ? SYM_DAH : SYM_DIT);
            exp_q.push_back(SYM_GAP);
        end else if (c == 8'h20) begin
            exp_q.push_back(SYM_SPACE);
        end
    endfunction

    function automatic void decode_sym(input logic [2:0] s);
        int hit;
        case (s)
            SYM_DIT:   pat_s = {pat_s, "."};
            SYM_DAH:   pat_s = {pat_s, "-"};
            SYM_SPACE: decoded = {decoded, " "};
            SYM_GAP: begin
                hit = -1;
                for (int i = 0; i < 26; i++)
                    if (tbl[i] == pat_s) hit = i;
                decoded = (hit < 0) ? {decoded, "?"} :
                          $sformatf("%s%c", decoded, 8'h41 + hit);
                pat_s = "";
            end
            default: ;
        endcase
    endfunction

    // Monitor: keyer stall modelled by its own symbol durations.
    logic       acc_m;
    logic       prev_hold = 1'b0;
    logic [2:0] prev_sym = '0;
    int         kb = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
            kb = 0;
        end else begin
            acc_m = sym_valid && sym_ready && (kb == 0);
            if (!sym_valid) check("wait_when_invalid", sym_out, SYM_WAIT);
            if (prev_hold) check("hold_stable", sym_out, prev_sym);
            if (acc_m) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sym_extra: got %0d expected none", sym_out);
                end else begin
                    check("sym", sym_out, exp_q.pop_front());
                end
                decode_sym(sym_out);
`ifdef MORSE_KEY_EN
                kb = ((sym_out == SYM_DAH || sym_out == SYM_SPACE) ?
                      4 * UC : 2 * UC) - 1;
`endif
            end else if (kb > 0) begin
                kb--;
            end
            prev_hold = sym_valid && !acc_m;
            prev_sym  = sym_out;
        end
    end

    task automatic send(input logic [7:0] c);
        int t = 0;
        @(negedge clk);
        char_in = c;
        char_valid = 1'b1;
        while (!char_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!char_ready) check("send_timeout", 0, 1);
        @(posedge clk);
        #1 char_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while ((exp_q.size() != 0 || !char_ready) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    logic [7:0] bad_set[5] = '{8'h35, 8'h40, 8'h5B, 8'h60, 8'h7B};

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_char_ready", char_ready, 1);
        check("rst_sym_valid", sym_valid, 0);
        check("rst_sym_out", sym_out, SYM_WAIT);
        check("rst_bad_char", bad_char, 0);
`ifdef MORSE_KEY_EN
        check("rst_key_out", key_out, 0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // 'E': DIT, GAP back to back
        push_char("E");
        send("E");
`ifndef MORSE_KEY_EN
        @(negedge clk);
        check("e_busy", char_ready, 0);
        @(negedge clk);
        check("e_gap_busy", char_ready, 0);
        @(negedge clk);
        check("e_ready_back", char_ready, 1);
`endif
        wait_done();

        // 'q' with the second symbol stalled for 3 cycles
        push_char("q");
        send("q");
        @(posedge clk);
        #1 sym_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 sym_ready = 1'b1;
        wait_done();

        // "H I" through the decoder model
        decoded = "";
        push_char("H");
        push_char(8'h20);
        push_char("I");
        send("H");
        send(8'h20);
        send("I");
        wait_done();
        check_str("decode_h_i", decoded, "H I");

        // Unsupported characters, including the bytes next to each range
        foreach (bad_set[i]) begin
            send(bad_set[i]);
            check("bad_pulse", bad_char, 1);
            check("bad_no_sym", sym_valid, 0);
            check("bad_ready", char_ready, 1);
            @(posedge clk);
            #1 check("bad_one_cycle", bad_char, 0);
        end

        // Reset during 2nd element of 'B', then 'T'
        push_char("B");
        send("B");
        begin
            int t = 0;
            @(negedge clk);
            while (!(sym_valid && sym_out == SYM_DIT) && t < 2000) begin
                @(negedge clk);
                t++;
            end
            check("b_second_elem", sym_out, SYM_DIT);
        end
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", sym_valid, 0);
        check("mid_rst_sym", sym_out, SYM_WAIT);
        check("mid_rst_ready", char_ready, 1);
        exp_q.delete();
        pat_s = "";
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        decoded = "";
        push_char("T");
        send("T");
        wait_done();
        check_str("decode_t", decoded, "T");

`ifdef MORSE_KEY_EN
        // Key line for 'A' with UNIT_CYCLES = 4
        begin
            string got = "";
            string want = {"0", "1111", "0000", "111111111111",
                           "0000", "00000000"};
            repeat (40) @(posedge clk);
            decoded = "";
            push_char("A");
            send("A");
            for (int i = 0; i < 33; i++) begin
                @(negedge clk);
                got = {got, key_out ? "1" : "0"};
            end
            check_str("key_a", got, want);
            wait_done();
            check_str("decode_a", decoded, "A");
        end
`endif

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
